conv2d_mac_array: RTL and testbench

Parametrised K×K convolution engine: the generalised successor to our single-MAC serial convolver. It processes one window of K×K taps per transaction through U parallel MAC lanes. It supports signed or unsigned operands, a run-time output shift with saturation, and valid/ready handshakes on both sides. It sits between the line-buffer/window generator and the activation/pooling stage, and is the DSE vehicle for sweeping unroll factor against area.

---
 rtl/conv2d_mac_array.sv | 134 +++++++++++++
 tb/tb_conv2d_mac_array.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_mac_array.sv
// Convolves one KxK window with its weights through U parallel MAC lanes; result is shifted, then saturated.
// Latency ceil(K*K/U) cycles from accept; the result holds in OUT until out_ready, and in_ready stays low while busy.
module conv2d_mac_array #(
    parameter int DW     = 8,
    parameter int K      = 3,
    parameter int U      = 1,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K*K*DW-1:0]     win,
    input  logic [K*K*DW-1:0]     ker,
    input  logic [4:0]            shift,
    output logic [OUT_W-1:0]      out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam int TAPS = K * K;
    localparam int IW   = $clog2(TAPS + U);
    localparam int NT   = 2 ** IW;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUT} state_t;

    state_t               state, state_nxt;
    logic [K*K*DW-1:0]    win_r, ker_r;
    logic [4:0]           shift_r;
    logic [ACC_W-1:0]     acc, grp, full, shifted;
    logic [OUT_W-1:0]     sat;
    logic [IW-1:0]        idx;
    logic [DW-1:0]        win_t [NT];
    logic [DW-1:0]        ker_t [NT];
    logic                 accept, last;

    function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v);
        return (SIGNED != 0) ? {{(ACC_W-DW){v[DW-1]}}, v} : {{(ACC_W-DW){1'b0}}, v};
    endfunction

    // Taps past the end of the window read as zero, so a partial last group needs no masking.
    for (genvar g = 0; g < NT; g++) begin : g_tap
        if (g < TAPS) begin : g_live
            assign win_t[g] = win_r[g*DW +: DW];
            assign ker_t[g] = ker_r[g*DW +: DW];
        end else begin : g_pad
            assign win_t[g] = '0;
            assign ker_t[g] = '0;
        end
    end

    assign accept = in_valid && in_ready;
    assign last   = (idx + IW'(U)) >= IW'(TAPS);

    always_comb begin
        grp = '0;
        for (int j = 0; j < U; j++)
            grp = grp + ext(win_t[idx + IW'(j)]) * ext(ker_t[idx + IW'(j)]);
    end

    assign full = acc + grp;

    always_comb begin
        shifted = '0;
        if (SIGNED != 0)
            shifted = $signed(full) >>> shift_r;
        else
            shifted = full >> shift_r;
    end

    // In range when every bit above the result's sign (or MSB) position agrees.
    always_comb begin
        sat = shifted[OUT_W-1:0];
        if (SIGNED != 0) begin
            if (!(&shifted[ACC_W-1:OUT_W-1]) && (|shifted[ACC_W-1:OUT_W-1]))
                sat = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            if (|shifted[ACC_W-1:OUT_W])
                sat = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_COMPUTE;
            S_COMPUTE: if (last)   state_nxt = S_OUT;
            S_OUT:     if (out_ready) state_nxt = in_valid ? S_COMPUTE : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = !rst && (state == S_IDLE || (state == S_OUT && out_ready));
        busy     = (state == S_COMPUTE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_r     <= '0;
            ker_r     <= '0;
            shift_r   <= '0;
            acc       <= '0;
            idx       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == S_OUT && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                win_r   <= win;
                ker_r   <= ker;
                shift_r <= shift;
                acc     <= '0;
                idx     <= '0;
            end else if (state == S_COMPUTE) begin
                if (last) begin
                    out       <= sat;
                    out_valid <= 1'b1;
                end else begin
                    acc <= full;
                    idx <= idx + IW'(U);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv2d_mac_array.sv
// Bench for conv2d_mac_array: ten instances covering U in {1,2,3,4,9}, unsigned and signed,
// exercised with directed cases, random windows against an arithmetic model, backpressure and reset abort.
module tb_conv2d_mac_array;
    localparam int NC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_v  [NC];
    logic        in_ready_v  [NC];
    logic [71:0] win_v       [NC];
    logic [71:0] ker_v       [NC];
    logic [4:0]  shift_v     [NC];
    logic [15:0] out_v       [NC];
    logic        out_valid_v [NC];
    logic        out_ready_v [NC];
    logic        busy_v      [NC];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        conv2d_mac_array #(
            .DW(8), .K(3), .U((g % 5 == 4) ? 9 : (g % 5) + 1),
            .ACC_W(20), .OUT_W(16), .SIGNED(g / 5)
        ) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]),
            .win(win_v[g]), .ker(ker_v[g]), .shift(shift_v[g]),
            .out(out_v[g]), .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]),
            .busy(busy_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lanes(input int c);
        return (c % 5 == 4) ? 9 : (c % 5) + 1;
    endfunction

    function automatic int lat(input int c);
        return (9 + lanes(c) - 1) / lanes(c);
    endfunction

    function automatic logic [15:0] model(input bit sgn, input logic [71:0] w,
                                          input logic [71:0] kk, input logic [4:0] sh);
        longint s = 0;
        longint a, b;
        for (int i = 0; i < 9; i++) begin
            a = sgn ? longint'($signed(w[i*8 +: 8]))  : longint'(w[i*8 +: 8]);
            b = sgn ? longint'($signed(kk[i*8 +: 8])) : longint'(kk[i*8 +: 8]);
            s += a * b;
        end
        s = s >>> sh;
        if (sgn) begin
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
        end else if (s > 65535) begin
            s = 65535;
        end
        return 16'(s);
    endfunction

    function automatic logic [71:0] rnd72();
        return {$urandom(), $urandom(), 8'($urandom())};
    endfunction

    // Waits (bounded) for out_valid after an accept sampled at #1; returns cycles and busy count.
    task automatic wait_result(input int c, output int k, output int nb);
        k = 0;
        nb = 0;
        while (!out_valid_v[c] && k < 40) begin
            if (busy_v[c]) nb++;
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic txn(input int c, input logic [71:0] w, input logic [71:0] kk,
                       input logic [4:0] sh, input logic [15:0] exp, input string tag);
        int k, nb;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready_v[c]), 32'd1);
        in_valid_v[c] = 1'b1;
        win_v[c] = w;
        ker_v[c] = kk;
        shift_v[c] = sh;
        @(posedge clk); #1;
        in_valid_v[c] = 1'b0;
        win_v[c] = rnd72();
        ker_v[c] = rnd72();
        shift_v[c] = 5'($urandom_range(0, 31));
        wait_result(c, k, nb);
        chk({tag, "_lat"}, 32'(k), 32'(lat(c)));
        chk({tag, "_busy"}, 32'(nb), 32'(lat(c)));
        chk({tag, "_out"}, 32'(out_v[c]), 32'(exp));
        out_ready_v[c] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[c] = 1'b0;
        chk({tag, "_vclr"}, 32'(out_valid_v[c]), 32'd0);
    endtask

    initial begin
        logic [71:0] w, kk, w2, k2;
        logic [4:0]  sh, sh2;
        logic [15:0] e1, e2, held;
        int k, nb;

        for (int c = 0; c < NC; c++) begin
            in_valid_v[c] = 1'b0;
            win_v[c] = '0;
            ker_v[c] = '0;
            shift_v[c] = '0;
            out_ready_v[c] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(in_ready_v[0]), 32'd0);
        chk("rst_vld", 32'(out_valid_v[0]), 32'd0);
        chk("rst_out", 32'(out_v[5]), 32'd0);
        chk("rst_busy", 32'(busy_v[5]), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy", 32'(in_ready_v[0]), 32'd1);

        w = {9{8'd1}};
        kk = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        txn(0, w, kk, 5'd0, 16'd45, "ones");
        txn(0, {9{8'hff}}, {9{8'hff}}, 5'd0, 16'd65535, "usat");
        txn(0, {9{8'hff}}, {9{8'hff}}, 5'd4, 16'd36576, "ushf");
        txn(5, {9{8'h80}}, {9{8'h7f}}, 5'd0, 16'h8000, "ssat");
        txn(5, {9{8'h80}}, {9{8'h7f}}, 5'd3, 16'hb890, "sshf");

        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < 3; r++) begin
                w = rnd72();
                kk = rnd72();
                sh = 5'($urandom_range(0, 8));
                txn(c, w, kk, sh, model(c >= 5, w, kk, sh), $sformatf("rnd_c%0d_%0d", c, r));
            end
        end

        // Backpressure: in_valid stays high with junk while busy and while the result is held.
        w = rnd72(); kk = rnd72(); sh = 5'($urandom_range(0, 6));
        e1 = model(1'b0, w, kk, sh);
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        win_v[0] = w; ker_v[0] = kk; shift_v[0] = sh;
        @(posedge clk); #1;
        win_v[0] = rnd72(); ker_v[0] = rnd72();
        chk("bp_rdy_busy", 32'(in_ready_v[0]), 32'd0);
        wait_result(0, k, nb);
        chk("bp_lat", 32'(k), 32'd9);
        chk("bp_out", 32'(out_v[0]), 32'(e1));
        held = out_v[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", 32'(out_v[0]), 32'(held));
            chk("bp_hvld", 32'(out_valid_v[0]), 32'd1);
            chk("bp_hrdy", 32'(in_ready_v[0]), 32'd0);
        end
        w2 = rnd72(); k2 = rnd72(); sh2 = 5'($urandom_range(0, 6));
        e2 = model(1'b0, w2, k2, sh2);
        win_v[0] = w2; ker_v[0] = k2; shift_v[0] = sh2;
        out_ready_v[0] = 1'b1;
        #1;
        chk("bp_both_rdy", 32'(in_ready_v[0]), 32'd1);
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b0;
        win_v[0] = rnd72();
        chk("bp_vclr", 32'(out_valid_v[0]), 32'd0);
        chk("bp_busy2", 32'(busy_v[0]), 32'd1);
        wait_result(0, k, nb);
        chk("bp_lat2", 32'(k), 32'd9);
        chk("bp_out2", 32'(out_v[0]), 32'(e2));
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;

        // Reset during the 4th compute cycle discards the transaction.
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        win_v[0] = {9{8'hff}}; ker_v[0] = {9{8'hff}}; shift_v[0] = 5'd0;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_vld", 32'(out_valid_v[0]), 32'd0);
        chk("abort_out", 32'(out_v[0]), 32'd0);
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_rdy", 32'(in_ready_v[0]), 32'd1);
        txn(0, {9{8'd2}}, {9{8'd3}}, 5'd0, 16'd54, "post");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
